// File: rtl/pc_ir_unit.sv
// Program-counter / instruction-register stage of the multi-cycle CPU: holds PC, IR and MDR,
// applies the controller-selected PC update, decodes IR fields, and keeps debug state.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic [1:0]  PCSource,
    input  logic        IRWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic        Zero,
    input  logic [31:0] MemData,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic [5:0]  OpCode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic [31:0] JumpTarget,
    output logic [31:0] MDR,
    output logic [31:0] FetchCount,
    output logic        PCMisaligned,
    output logic        PCSrcError
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        pc_misaligned_q, pc_misaligned_d;
    logic        pc_src_error_q, pc_src_error_d;

    logic        pc_en;
    logic [31:0] pc_mux;
    logic [31:0] jump_target;

    // PC already holds PC+4 by the time a jump is decoded, so its top nibble is used directly.
    assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        pc_en           = PCWrite | (PCWriteCond & Zero);
        pc_mux          = pc_q;
        pc_d            = pc_q;
        pc_misaligned_d = pc_misaligned_q;
        pc_src_error_d  = pc_src_error_q;
        ir_d            = ir_q;
        fetch_count_d   = fetch_count_q;
        mdr_d           = MemData;

        case (PCSource)
            2'b00:   pc_mux = ALUResult;
            2'b01:   pc_mux = ALUOut;
            2'b10:   pc_mux = jump_target;
            default: pc_mux = pc_q;
        endcase

        // Selector 11 is reserved: the write is refused and flagged instead.
        if (pc_en) begin
            if (PCSource == 2'b11) begin
                pc_src_error_d = 1'b1;
            end else begin
                pc_d = pc_mux;
                if (pc_mux[1:0] != 2'b00) begin
                    pc_misaligned_d = 1'b1;
                end
            end
        end

        if (IRWrite) begin
            ir_d          = MemData;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            ir_q            <= 32'h0;
            mdr_q           <= 32'h0;
            fetch_count_q   <= 32'h0;
            pc_misaligned_q <= 1'b0;
            pc_src_error_q  <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ir_q            <= ir_d;
            mdr_q           <= mdr_d;
            fetch_count_q   <= fetch_count_d;
            pc_misaligned_q <= pc_misaligned_d;
            pc_src_error_q  <= pc_src_error_d;
        end
    end

    assign PC           = pc_q;
    assign Instruction  = ir_q;
    assign OpCode       = ir_q[31:26];
    assign Rs           = ir_q[25:21];
    assign Rt           = ir_q[20:16];
    assign Rd           = ir_q[15:11];
    assign Shamt        = ir_q[10:6];
    assign Funct        = ir_q[5:0];
    assign Imm16        = ir_q[15:0];
    assign JumpTarget   = jump_target;
    assign MDR          = mdr_q;
    assign FetchCount   = fetch_count_q;
    assign PCMisaligned = pc_misaligned_q;
    assign PCSrcError   = pc_src_error_q;

endmodule
